// File: rtl/qam_frame_sync_pkg.sv
// Shared definitions for the QAM frame synchroniser: state encoding,
// default sync pattern and data path widths.
package qam_frame_sync_pkg;

   localparam int NIB_W  = 4;
   localparam int BYTE_W = 8;

   localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA5C3;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      LEN     = 2'd1,
      PAYLOAD = 2'd2
   } fsm_state_t;

endpackage

// File: rtl/qam_frame_sync_nibble_packer.sv
// Pairs consecutive nibbles (high first) into a byte. The strobe and byte are
// combinational on the completing nibble so the caller can register them.
module nibble_packer
   import qam_frame_sync_pkg::*;
(
   input  logic              dclk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              nib_en,
   input  logic [NIB_W-1:0]  nib,
   output logic [BYTE_W-1:0] byte_data,
   output logic              byte_stb
);

   logic [NIB_W-1:0] hi_nib;
   logic             phase;

   always_ff @(posedge dclk) begin
      if (!rst_n || clr) begin
         hi_nib <= '0;
         phase  <= 1'b0;
      end else if (nib_en) begin
         if (!phase) hi_nib <= nib;
         phase <= ~phase;
      end
   end

   assign byte_data = {hi_nib, nib};
   assign byte_stb  = nib_en && phase;

endmodule

// File: rtl/qam_frame_sync.sv
// Frame synchroniser: hunts for the sync word in a nibble stream, reads an
// 8-bit length, then assembles the payload into bytes behind a one-deep output stage.
//
// state   | meaning
// HUNT    | shifting nibbles, looking for SYNC_WORD
// LEN     | collecting the two length nibbles
// PAYLOAD | packing payload bytes until frame_len have transferred
module qam_frame_sync
   import qam_frame_sync_pkg::*;
#(
   parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT
)(
   input  logic              dclk,
   input  logic              rst_n,
   input  logic [NIB_W-1:0]  nib_in,
   input  logic              nib_valid,
   output logic              nib_ready,
   output logic [BYTE_W-1:0] byte_out,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              frame_start,
   output logic              frame_end,
   output logic [BYTE_W-1:0] frame_len,
   output logic              locked,
   output logic [BYTE_W-1:0] frame_count
);

   fsm_state_t        state;
   logic [11:0]       sync_hist;
   logic [15:0]       sync_next;
   logic [BYTE_W-1:0] xfer_cnt;
   logic [BYTE_W:0]   loaded_before;
   logic              nib_acc;
   logic              byte_xfer;
   logic              sync_hit;
   logic              leave;
   logic              pk_en;
   logic              pk_stb;
   logic [BYTE_W-1:0] pk_byte;

   assign nib_ready = !(byte_valid && !byte_ready);
   assign nib_acc   = nib_valid && nib_ready;
   assign byte_xfer = byte_valid && byte_ready;

   // sync_hist keeps the three older nibbles; the newest arrives on nib_in
   assign sync_next = {sync_hist, nib_in};
   assign sync_hit  = (state == HUNT) && nib_acc && (sync_next == SYNC_WORD);

   // bytes handed to the output stage so far, counting one leaving this cycle
   assign loaded_before = {1'b0, xfer_cnt} + {{BYTE_W{1'b0}}, byte_xfer};

   assign pk_en = nib_acc && (state == LEN || state == PAYLOAD);

   always_comb begin
      leave = 1'b0;
      case (state)
         HUNT:    leave = sync_hit;
         LEN:     leave = pk_stb;
         PAYLOAD: leave = byte_xfer && frame_end;
         default: leave = 1'b1;
      endcase
   end

   nibble_packer u_packer (
      .dclk      (dclk),
      .rst_n     (rst_n),
      .clr       (leave),
      .nib_en    (pk_en),
      .nib       (nib_in),
      .byte_data (pk_byte),
      .byte_stb  (pk_stb)
   );

   always_ff @(posedge dclk) begin
      if (!rst_n) begin
         state       <= HUNT;
         sync_hist   <= '0;
         xfer_cnt    <= '0;
         byte_out    <= '0;
         byte_valid  <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         frame_len   <= '0;
         locked      <= 1'b0;
         frame_count <= '0;
      end else begin
         if (state == PAYLOAD && pk_stb) begin
            byte_out    <= pk_byte;
            byte_valid  <= 1'b1;
            frame_start <= (loaded_before == '0);
            frame_end   <= (loaded_before + 1'b1 == {1'b0, frame_len});
         end else if (byte_xfer) begin
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
         end

         if (byte_xfer) xfer_cnt <= xfer_cnt + 1'b1;

         case (state)
            HUNT: begin
               if (nib_acc) begin
                  sync_hist <= sync_next[11:0];
                  if (sync_hit) begin
                     state  <= LEN;
                     locked <= 1'b1;
                  end
               end
            end
            LEN: begin
               sync_hist <= '0;
               if (pk_stb) begin
                  frame_len <= pk_byte;
                  xfer_cnt  <= '0;
                  if (pk_byte != '0) begin
                     state <= PAYLOAD;
                  end else begin
                     frame_count <= frame_count + 1'b1;
                     locked      <= 1'b0;
                     state       <= HUNT;
                  end
               end
            end
            PAYLOAD: begin
               sync_hist <= '0;
               if (byte_xfer && frame_end) begin
                  frame_count <= frame_count + 1'b1;
                  locked      <= 1'b0;
                  state       <= HUNT;
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_qam_frame_sync.sv
// Scoreboard bench for qam_frame_sync: directed nibble streams push expected
// bytes into a queue that a separate monitor pops on each byte transfer.
module tb_qam_frame_sync;

   logic       dclk = 1'b0;
   logic       rst_n;
   logic [3:0] nib_in;
   logic       nib_valid;
   logic       nib_ready;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       byte_ready;
   logic       frame_start;
   logic       frame_end;
   logic [7:0] frame_len;
   logic       locked;
   logic [7:0] frame_count;

   always #5 dclk = ~dclk;

   qam_frame_sync dut (
      .dclk        (dclk),
      .rst_n       (rst_n),
      .nib_in      (nib_in),
      .nib_valid   (nib_valid),
      .nib_ready   (nib_ready),
      .byte_out    (byte_out),
      .byte_valid  (byte_valid),
      .byte_ready  (byte_ready),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .frame_len   (frame_len),
      .locked      (locked),
      .frame_count (frame_count)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       fs;
      logic       fe;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_fc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic push(input logic [7:0] d, input logic fs, input logic fe);
      exp_t e;
      e.data = d;
      e.fs   = fs;
      e.fe   = fe;
      exp_q.push_back(e);
   endtask

   // inputs change at negedge+1; byte_ready only at negedge; monitor at negedge+2
   task automatic send_nib(input logic [3:0] n);
      int t;
      t = 0;
      @(negedge dclk); #1;
      nib_in    = n;
      nib_valid = 1'b1;
      while (!nib_ready && t < 200) begin
         @(negedge dclk); #1;
         t++;
      end
      if (t >= 200) timeout("nib_ready_wait");
   endtask

   task automatic send_word(input logic [63:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) send_nib(w[4*i +: 4]);
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(negedge dclk); #1;
         nib_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 400) begin
         @(negedge dclk);
         t++;
      end
      if (t >= 400) timeout("drain_wait");
      repeat (3) @(negedge dclk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_byte_out"},    byte_out,    8'h00);
      chk({tag, "_byte_valid"},  byte_valid,  1'b0);
      chk({tag, "_frame_start"}, frame_start, 1'b0);
      chk({tag, "_frame_end"},   frame_end,   1'b0);
      chk({tag, "_frame_len"},   frame_len,   8'h00);
      chk({tag, "_locked"},      locked,      1'b0);
      chk({tag, "_frame_count"}, frame_count, 8'h00);
   endtask

   task automatic do_reset(input string tag);
      @(negedge dclk); #1;
      nib_valid = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(negedge dclk);
      #1;
      chk_reset_outputs(tag);
      rst_n = 1'b1;
      @(negedge dclk); #1;
      chk({tag, "_nib_ready"}, nib_ready, 1'b1);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge dclk); #2;
         if (rst_n && byte_valid && byte_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got %0h expected none", byte_out);
            end else begin
               e = exp_q.pop_front();
               chk("byte_out",    byte_out,    e.data);
               chk("frame_start", frame_start, e.fs);
               chk("frame_end",   frame_end,   e.fe);
            end
         end
      end
   end

   initial begin : main
      rst_n      = 1'b0;
      nib_valid  = 1'b0;
      nib_in     = 4'h0;
      byte_ready = 1'b1;
      exp_fc     = 8'd0;

      repeat (3) @(negedge dclk);
      #1;
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge dclk); #1;
      chk("reset_nib_ready", nib_ready, 1'b1);

      // basic two-byte frame
      push(8'h12, 1'b1, 1'b0);
      push(8'h34, 1'b0, 1'b1);
      send_word(64'hA5C302, 6);
      idle(1);
      chk("t1_locked_mid", locked, 1'b1);
      chk("t1_frame_len", frame_len, 8'd2);
      send_word(64'h1234, 4);
      idle(1);
      wait_drain();
      exp_fc = 8'd1;
      chk("t1_frame_count", frame_count, exp_fc);
      chk("t1_locked_after", locked, 1'b0);
      chk("t1_byte_valid_after", byte_valid, 1'b0);

      // noise with a false partial match, then a one-byte frame
      push(8'h7E, 1'b1, 1'b1);
      send_word(64'hFA5A5C, 6);
      idle(2);
      chk("t2_no_early_lock", locked, 1'b0);
      send_word(64'h3017E, 5);
      idle(1);
      wait_drain();
      exp_fc = 8'd2;
      chk("t2_frame_count", frame_count, exp_fc);
      chk("t2_frame_len", frame_len, 8'd1);

      // zero-length frame on its own
      send_word(64'hA5C300, 6);
      idle(2);
      exp_fc = 8'd3;
      chk("t3_frame_count", frame_count, exp_fc);
      chk("t3_locked", locked, 1'b0);
      chk("t3_frame_len", frame_len, 8'd0);

      // zero-length frame followed immediately by another sync
      push(8'h55, 1'b1, 1'b1);
      send_word(64'hA5C300A5C30155, 14);
      idle(1);
      wait_drain();
      exp_fc = 8'd5;
      chk("t3b_frame_count", frame_count, exp_fc);

      // three-byte frame with downstream stalled after the first byte
      push(8'h11, 1'b1, 1'b0);
      push(8'h22, 1'b0, 1'b0);
      push(8'h33, 1'b0, 1'b1);
      fork
         begin
            send_word(64'hA5C303112233, 12);
            idle(1);
         end
         begin
            int t;
            t = 0;
            while (!byte_valid && t < 200) begin
               @(negedge dclk);
               t++;
            end
            if (t >= 200) timeout("t4_first_byte_wait");
            byte_ready = 1'b0;
            repeat (5) begin
               @(negedge dclk); #3;
               chk("t4_stall_byte_out", byte_out, 8'h11);
               chk("t4_stall_valid", byte_valid, 1'b1);
               chk("t4_stall_start", frame_start, 1'b1);
               chk("t4_stall_nib_ready", nib_ready, 1'b0);
            end
            @(negedge dclk);
            byte_ready = 1'b1;
         end
      join
      wait_drain();
      exp_fc = 8'd6;
      chk("t4_frame_count", frame_count, exp_fc);

      // reset after three of four payload nibbles
      push(8'h12, 1'b1, 1'b0);
      send_word(64'hA5C302123, 9);
      idle(1);
      wait_drain();
      do_reset("t5");
      exp_fc = 8'd0;
      push(8'h9B, 1'b1, 1'b0 | 1'b1);
      send_word(64'hA5C3019B, 8);
      idle(1);
      wait_drain();
      exp_fc = 8'd1;
      chk("t5_frame_count", frame_count, exp_fc);
      chk("t5_frame_len", frame_len, 8'd1);

      // maximum length frame
      for (int i = 0; i < 255; i++) push(i[7:0], i == 0, i == 254);
      send_word(64'hA5C3FF, 6);
      for (int i = 0; i < 255; i++) send_word({56'd0, i[7:0]}, 2);
      idle(1);
      wait_drain();
      exp_fc = 8'd2;
      chk("t6_frame_count", frame_count, exp_fc);
      chk("t6_frame_len", frame_len, 8'hFF);
      chk("t6_locked", locked, 1'b0);

      // frame counter wrap with zero-length frames
      do_reset("t7");
      repeat (255) send_word(64'hA5C300, 6);
      idle(2);
      chk("t7_frame_count_255", frame_count, 8'd255);
      send_word(64'hA5C300, 6);
      idle(2);
      chk("t7_frame_count_wrap", frame_count, 8'd0);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/qam_frame_sync.md
QAM_FRAME_SYNC -- requirements
Module: qam_frame_sync

Interface
- REQ-001 Parameter SYNC_WORD, default 16'hA5C3: frame sync pattern, most-significant nibble first.
- REQ-002 dclk  input  1  data clock; all state updates on its rising edge.
- REQ-003 rst_n  input  1  reset, synchronous, active-low.
- REQ-004 nib_in  input  4  demapped symbol nibble from the demapper FIFO output.
- REQ-005 nib_valid  input  1  nib_in holds a valid nibble.
- REQ-006 nib_ready  output  1  block accepts nib_in this cycle; a nibble transfers when nib_valid && nib_ready.
- REQ-007 byte_out  output  8  assembled payload byte.
- REQ-008 byte_valid  output  1  byte_out is valid.
- REQ-009 byte_ready  input  1  downstream accepts byte_out; a byte transfers when byte_valid && byte_ready.
- REQ-010 frame_start  output  1  qualifies byte_out as the first payload byte of a frame.
- REQ-011 frame_end  output  1  qualifies byte_out as the last payload byte of a frame.
- REQ-012 frame_len  output  8  payload length of the current frame, held until the next length field.
- REQ-013 locked  output  1  high from sync detection until the frame's last payload byte transfers.
- REQ-014 frame_count  output  8  count of completed frames, wraps 255->0.

Function
- REQ-015 FSM states: HUNT, LEN, PAYLOAD.
- REQ-016 HUNT: each accepted nibble shifts into a 16-bit register (new nibble enters at the LSBs).
  - When the register equals SYNC_WORD after a shift, the FSM goes to LEN on the next cycle and locked rises.
  - The shift register is cleared on entry to HUNT.
- REQ-017 LEN: two accepted nibbles, high nibble first, form frame_len.
  - Length nonzero: go to PAYLOAD.
  - Length zero: increment frame_count, drop locked, return to HUNT; no byte is emitted.
- REQ-018 PAYLOAD: each pair of accepted nibbles (high first) forms one byte.
  - The byte is presented on byte_out with byte_valid the cycle after the second nibble is accepted (latency 1).
- REQ-019 An internal payload counter counts transferred bytes.
  - When the transferred count equals frame_len, increment frame_count, drop locked, and enter HUNT on the next cycle.
- REQ-020 frame_start is high with byte_valid for payload byte 1; frame_end is high with byte_valid for byte frame_len.
  - Both are high together when frame_len==1.
- REQ-021 Output register is a single holding stage.
  - byte_out, byte_valid, frame_start and frame_end hold stable while byte_valid && !byte_ready.
- REQ-022 nib_ready = !(byte_valid && !byte_ready), in every state.
  - A held byte stalls HUNT and LEN as well.
- REQ-023 Simultaneous transfer: when a byte transfers and a completing nibble is accepted in the same cycle, the new byte loads and byte_valid stays high with no bubble.
- REQ-024 A nibble is never accepted while nib_valid is low.
- REQ-025 Sync patterns appearing inside LEN or PAYLOAD are treated as data; there is no re-hunt until the frame completes.
- REQ-026 frame_len 255 is legal.
- REQ-027 The payload counter is 8 bits and does not wrap within a frame.

Reset
- REQ-028 While rst_n is low at a dclk edge, the block enters the following state:
  - FSM to HUNT; sync shift register and nibble/byte assembly state cleared;
  - byte_out=0, byte_valid=0, frame_start=0, frame_end=0, frame_len=0, locked=0, frame_count=0;
  - nib_ready=1 once reset is released.
- REQ-029 Reset asserted mid-frame abandons the frame.
  - No partial byte is emitted and frame_count is not incremented.

Structure
- REQ-030 A shared package holds the following; SYNC_WORD default is defined there and overridable per instance:
  - the FSM state encoding (HUNT=2'd0, LEN=2'd1, PAYLOAD=2'd2);
  - the SYNC_WORD default;
  - the nibble/byte width constants.
- REQ-031 One sub-module, nibble_packer, holds the high-nibble register and phase bit and emits an assembled byte plus a strobe.
  - It is cleared by rst_n and on every FSM state change.

Verification
- REQ-032 Nibbles A,5,C,3,0,2,1,2,3,4 with byte_ready=1 -> bytes 8'h12 (frame_start=1) then 8'h34 (frame_end=1); frame_len=2; frame_count=1; locked low after the 8'h34 transfer.
- REQ-033 Noise nibbles F,A,5,A,5,C,3 then 0,1,7,E -> a single byte 8'h7E with frame_start=frame_end=1; a false partial match does not lock early.
- REQ-034 Sync then length 00 -> no byte_valid; frame_count increments by 1; next sync is detected immediately.
- REQ-035 Frame length 3 with byte_ready held low for 5 cycles after the first byte:
  - byte_out stays 8'h11 and stable throughout;
  - nib_ready stays 0 throughout;
  - no nibble is lost or duplicated.
- REQ-036 rst_n pulsed low after 3 of 4 payload nibbles -> all outputs return to reset values; a following clean frame decodes correctly; frame_count=1.
- REQ-037 256 zero-length frames back to back -> frame_count wraps to 0.
